// File: rtl/avmm_ccip_burst_splitter.sv
// Splits Avalon-MM bursts of 1..64 lines into naturally aligned CCI-P sub-bursts of 1, 2 or 4 lines.
// Zero-latency command/data pass-through. Backpressure: s_waitrequest follows m_waitrequest, and is held high while read sub-bursts drain. Optional macro: AVMM_SPLIT_FENCE_FIRST_EN.
module avmm_ccip_burst_splitter #(
    parameter int ADDR_WIDTH    = 49,
    parameter int DATA_WIDTH    = 512,
    parameter int S_BURST_WIDTH = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     s_address,
    input  logic [S_BURST_WIDTH-1:0]  s_burstcount,
    input  logic                      s_read,
    input  logic                      s_write,
    input  logic [DATA_WIDTH-1:0]     s_writedata,
    input  logic [DATA_WIDTH/8-1:0]   s_byteenable,
    output logic                      s_waitrequest,
    output logic [DATA_WIDTH-1:0]     s_readdata,
    output logic                      s_readdatavalid,
    output logic [ADDR_WIDTH-1:0]     m_address,
    output logic [2:0]                m_burstcount,
    output logic                      m_read,
    output logic                      m_write,
    output logic [DATA_WIDTH-1:0]     m_writedata,
    output logic [DATA_WIDTH/8-1:0]   m_byteenable,
    input  logic                      m_waitrequest,
    input  logic [DATA_WIDTH-1:0]     m_readdata,
    input  logic                      m_readdatavalid
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_SPLIT = 2'd1;
    localparam logic [1:0] WR_SPLIT = 2'd2;
    localparam int FENCE_BIT = 48;

    typedef logic [S_BURST_WIDTH-1:0] cnt_t;
    typedef logic [ADDR_WIDTH-1:0]    addr_t;

    function automatic cnt_t widen(input logic [2:0] sz);
        return {{(S_BURST_WIDTH-3){1'b0}}, sz};
    endfunction

    function automatic logic [2:0] sub_size(input logic [1:0] off, input cnt_t r);
        logic [2:0] sz;
        sz = 3'd1;
        if (off == 2'b00 && r >= widen(3'd4))
            sz = 3'd4;
        else if (!off[0] && r >= widen(3'd2))
            sz = 3'd2;
        return sz;
    endfunction

    // The fence bit sits above the byte address, so the add stops short of it.
    function automatic addr_t next_addr(input addr_t a, input logic [2:0] sz);
        addr_t n;
        n = a;
        n[FENCE_BIT-1:0] = a[FENCE_BIT-1:0] + {{(FENCE_BIT-9){1'b0}}, sz, 6'b0};
        return n;
    endfunction

    logic [1:0] state_q, state_d;
    addr_t      addr_q, addr_d;
    cnt_t       rem_q, rem_d;
    cnt_t       sub_rem_q, sub_rem_d;
    logic [2:0] size_q, size_d;

    cnt_t       burst_eff;
    logic [2:0] idle_size;
    logic [2:0] rd_size;
    cnt_t       rd_rem_n;

    addr_t      wr_addr, wr_addr_roll;
    logic [2:0] wr_size, wr_size_roll;
    cnt_t       wr_sub, wr_tot, wr_tot_n;
    logic       wr_roll;

    logic       rd_c, wr_c;

    assign burst_eff = (s_burstcount == '0) ? cnt_t'(1) : s_burstcount;
    assign idle_size = sub_size(s_address[7:6], burst_eff);
    assign rd_size   = sub_size(addr_q[7:6], rem_q);
    assign rd_rem_n  = rem_q - widen(rd_size);

    // Current write sub-burst context: taken from the slave port in IDLE, from registers afterwards.
    always_comb begin
        if (state_q == WR_SPLIT) begin
            wr_addr = addr_q;
            wr_size = size_q;
            wr_sub  = sub_rem_q;
            wr_tot  = rem_q;
        end else begin
            wr_addr = s_address;
            wr_size = idle_size;
            wr_sub  = widen(idle_size);
            wr_tot  = burst_eff;
        end
        wr_tot_n     = wr_tot - cnt_t'(1);
        wr_roll      = (wr_sub == cnt_t'(1));
        wr_addr_roll = next_addr(wr_addr, wr_size);
`ifdef AVMM_SPLIT_FENCE_FIRST_EN
        wr_addr_roll[FENCE_BIT] = 1'b0;
`endif
        wr_size_roll = sub_size(wr_addr_roll[7:6], wr_tot_n);
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        sub_rem_d     = sub_rem_q;
        size_d        = size_q;
        m_address     = s_address;
        m_burstcount  = idle_size;
        rd_c          = 1'b0;
        wr_c          = 1'b0;
        s_waitrequest = m_waitrequest;
        case (state_q)
            IDLE: begin
                if (s_write) begin
                    wr_c = 1'b1;
                end else if (s_read) begin
                    rd_c = 1'b1;
                    if (!m_waitrequest && burst_eff > widen(idle_size)) begin
                        addr_d  = next_addr(s_address, idle_size);
                        rem_d   = burst_eff - widen(idle_size);
                        state_d = RD_SPLIT;
                    end
                end
            end
            RD_SPLIT: begin
                s_waitrequest = 1'b1;
                rd_c          = 1'b1;
                m_address     = addr_q;
                m_burstcount  = rd_size;
                if (!m_waitrequest) begin
                    addr_d = next_addr(addr_q, rd_size);
                    rem_d  = rd_rem_n;
                    if (rd_rem_n == '0)
                        state_d = IDLE;
                end
            end
            WR_SPLIT: begin
                wr_c         = s_write;
                m_address    = addr_q;
                m_burstcount = size_q;
            end
            default: state_d = IDLE;
        endcase

        if (wr_c && !m_waitrequest) begin
            addr_d    = wr_roll ? wr_addr_roll : wr_addr;
            size_d    = wr_roll ? wr_size_roll : wr_size;
            sub_rem_d = wr_roll ? widen(wr_size_roll) : wr_sub - cnt_t'(1);
            rem_d     = wr_tot_n;
            state_d   = (wr_tot_n == '0) ? IDLE : WR_SPLIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            sub_rem_q <= '0;
            size_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            sub_rem_q <= sub_rem_d;
            size_q    <= size_d;
        end
    end

    assign m_read          = rd_c & ~reset;
    assign m_write         = wr_c & ~reset;
    assign m_writedata     = s_writedata;
    assign m_byteenable    = s_byteenable;
    assign s_readdata      = m_readdata;
    assign s_readdatavalid = m_readdatavalid;

endmodule

// File: tb/tb_avmm_ccip_burst_splitter.sv
// Randomized bench for avmm_ccip_burst_splitter: a queue-based model expands each slave burst into
// expected master sub-bursts, write beats and read data, and a negedge monitor compares against it.
module tb_avmm_ccip_burst_splitter;
    localparam int AW = 49;
    localparam int DW = 512;
    localparam int BW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] s_address;
    logic [BW-1:0] s_burstcount;
    logic          s_read, s_write;
    logic [DW-1:0] s_writedata;
    logic [DW/8-1:0] s_byteenable;
    logic          s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic          s_readdatavalid;
    logic [AW-1:0] m_address;
    logic [2:0]    m_burstcount;
    logic          m_read, m_write;
    logic [DW-1:0] m_writedata;
    logic [DW/8-1:0] m_byteenable;
    logic          m_waitrequest;
    logic [DW-1:0] m_readdata;
    logic          m_readdatavalid;

    always #5 clk = ~clk;

    avmm_ccip_burst_splitter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .S_BURST_WIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
    );

    typedef struct packed { logic [AW-1:0] a; logic [2:0] sz; logic last; } hdr_t;
    typedef struct packed { logic [AW-1:0] a; logic [2:0] sz; logic [DW-1:0] d; logic [DW/8-1:0] be; } wbeat_t;

    hdr_t          gen_q[$];
    hdr_t          exp_rd_q[$];
    wbeat_t        exp_wr_q[$];
    logic [DW-1:0] exp_rdata_q[$];
    logic [DW-1:0] resp_q[$];
    logic [DW-1:0] wdat[64];
    logic [DW/8-1:0] wbe[64];

    int checks = 0;
    int failures = 0;
    int mode = 0;
    bit in_reset = 1'b1;
    bit rd_split = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expands one slave burst into sub-bursts from the alignment rule alone.
    function automatic void gen(input logic [AW-1:0] a, input int n, input bit wr);
        logic [AW-1:0] cur;
        int r, sz;
        bit first;
        hdr_t h;
        gen_q.delete();
        cur = a; r = n; first = 1'b1;
        while (r > 0) begin
            if (cur[7:6] == 2'b00 && r >= 4) sz = 4;
            else if (cur[6] == 1'b0 && r >= 2) sz = 2;
            else sz = 1;
            h.a = cur;
`ifdef AVMM_SPLIT_FENCE_FIRST_EN
            if (wr && !first) h.a[48] = 1'b0;
`else
            if (wr && !first) h.a[48] = cur[48];
`endif
            h.sz = 3'(sz);
            r -= sz;
            h.last = (r == 0);
            gen_q.push_back(h);
            cur[47:0] = cur[47:0] + 48'(sz * 64);
            first = 1'b0;
        end
    endfunction

    function automatic logic [DW-1:0] rdata_of(input logic [47:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = {a[47:6], 16'hBEEF, 3'(i), 3'b101};
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic wait_acc(input string name);
        int n = 0;
        bit acc = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = !s_waitrequest;
            @(posedge clk); #1;
            n++;
        end
        chk(name, DW'(acc), DW'(1));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int bc);
        int n;
        logic [47:0] la;
        n = (bc == 0) ? 1 : bc;
        gen(a, n, 1'b0);
        foreach (gen_q[i]) exp_rd_q.push_back(gen_q[i]);
        for (int i = 0; i < n; i++) begin
            la = a[47:0] + 48'(i * 64);
            exp_rdata_q.push_back(rdata_of(la));
        end
        s_address = a; s_burstcount = BW'(bc); s_read = 1'b1;
        wait_acc("rd_cmd_accept");
        s_read = 1'b0;
    endtask

    // gap: -1 none, -2 random, k>=0 two idle cycles before beat k
    task automatic do_write(input logic [AW-1:0] a, input int bc, input int gap);
        int n, idx, g;
        wbeat_t w;
        n = (bc == 0) ? 1 : bc;
        for (int i = 0; i < n; i++) begin
            wdat[i] = rand_wide();
            wbe[i]  = {$urandom, $urandom};
        end
        gen(a, n, 1'b1);
        idx = 0;
        foreach (gen_q[i]) begin
            for (int k = 0; k < int'(gen_q[i].sz); k++) begin
                w.a = gen_q[i].a; w.sz = gen_q[i].sz; w.d = wdat[idx]; w.be = wbe[idx];
                exp_wr_q.push_back(w);
                idx++;
            end
        end
        s_address = a; s_burstcount = BW'(bc);
        for (int i = 0; i < n; i++) begin
            g = (gap == -2) ? int'($urandom % 3) : ((gap == i) ? 2 : 0);
            s_write = 1'b0;
            for (int c = 0; c < g; c++) begin @(posedge clk); #1; end
            s_write = 1'b1; s_writedata = wdat[i]; s_byteenable = wbe[i];
            wait_acc("wr_beat_accept");
        end
        s_write = 1'b0;
    endtask

    // Slave-side memory model and master waitrequest pattern.
    initial begin
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0: m_waitrequest = 1'b0;
                1: m_waitrequest = ($urandom % 3 == 0);
                2: m_waitrequest = ~m_waitrequest;
                default: m_waitrequest = 1'b1;
            endcase
            if (!in_reset && resp_q.size() > 0 && (mode == 0 || $urandom % 4 != 0)) begin
                m_readdatavalid = 1'b1;
                m_readdata = resp_q.pop_front();
            end else begin
                m_readdatavalid = 1'b0;
                m_readdata = rand_wide();
            end
        end
    end

    initial begin
        hdr_t h;
        wbeat_t w;
        logic [47:0] la;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                rd_split = 1'b0;
            end else begin
                chk("rdvalid_pass", DW'(s_readdatavalid), DW'(m_readdatavalid));
                if (s_readdatavalid) begin
                    if (exp_rdata_q.size() == 0) chk("rdata_extra", DW'(1), DW'(0));
                    else chk("rdata_order", s_readdata, exp_rdata_q.pop_front());
                end
                if (rd_split) begin
                    chk("rdsplit_waitreq", DW'(s_waitrequest), DW'(1));
                    chk("rdsplit_mread", DW'(m_read), DW'(1));
                end else if (s_read || s_write) begin
                    chk("waitreq_pass", DW'(s_waitrequest), DW'(m_waitrequest));
                end
                if (m_read && !m_waitrequest) begin
                    if (exp_rd_q.size() == 0) begin
                        chk("rd_unexpected", DW'(m_address), DW'(0));
                    end else begin
                        h = exp_rd_q.pop_front();
                        chk("rd_addr", DW'(m_address), DW'(h.a));
                        chk("rd_size", DW'(m_burstcount), DW'(h.sz));
                        rd_split = !h.last;
                        for (int i = 0; i < int'(m_burstcount); i++) begin
                            la = m_address[47:0] + 48'(i * 64);
                            resp_q.push_back(rdata_of(la));
                        end
                    end
                end
                if (m_write && !m_waitrequest) begin
                    if (exp_wr_q.size() == 0) begin
                        chk("wr_unexpected", DW'(m_address), DW'(0));
                    end else begin
                        w = exp_wr_q.pop_front();
                        chk("wr_addr", DW'(m_address), DW'(w.a));
                        chk("wr_size", DW'(m_burstcount), DW'(w.sz));
                        chk("wr_data", m_writedata, w.d);
                        chk("wr_be", DW'(m_byteenable), DW'(w.be));
                    end
                end
            end
        end
    end

    task automatic flush();
        exp_rd_q.delete(); exp_wr_q.delete(); exp_rdata_q.delete(); resp_q.delete();
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [63:0] t;
        int n;

        // Hand-computed sub-burst lists pin the model.
        gen(49'h40, 7, 1'b0);
        chk("pin27_cnt", DW'(gen_q.size()), DW'(3));
        chk("pin27_a0", DW'({gen_q[0].a, gen_q[0].sz}), DW'({49'h40, 3'd1}));
        chk("pin27_a1", DW'({gen_q[1].a, gen_q[1].sz}), DW'({49'h80, 3'd2}));
        chk("pin27_a2", DW'({gen_q[2].a, gen_q[2].sz}), DW'({49'h100, 3'd4}));
        gen(49'h0, 8, 1'b1);
        chk("pin28", DW'({gen_q[0].a, gen_q[0].sz, gen_q[1].a, gen_q[1].sz}),
            DW'({49'h0, 3'd4, 49'h100, 3'd4}));
        gen(49'hC0, 3, 1'b1);
        chk("pin29", DW'({gen_q[0].a, gen_q[0].sz, gen_q[1].a, gen_q[1].sz}),
            DW'({49'hC0, 3'd1, 49'h100, 3'd2}));
        gen(49'h1_0000_0000_0080, 4, 1'b1);
`ifdef AVMM_SPLIT_FENCE_FIRST_EN
        chk("pin30", DW'({gen_q[0].a, gen_q[0].sz, gen_q[1].a, gen_q[1].sz}),
            DW'({49'h1_0000_0000_0080, 3'd2, 49'h0_0000_0000_0100, 3'd2}));
`else
        chk("pin30", DW'({gen_q[0].a, gen_q[0].sz, gen_q[1].a, gen_q[1].sz}),
            DW'({49'h1_0000_0000_0080, 3'd2, 49'h1_0000_0000_0100, 3'd2}));
`endif
        gen(49'h0, 64, 1'b0);
        chk("pin31_cnt", DW'(gen_q.size()), DW'(16));

        // Reset state: commands presented during reset must not reach the master.
        reset = 1'b1; s_address = '0; s_burstcount = 7'd4; s_read = 1'b1; s_write = 1'b1;
        s_writedata = '0; s_byteenable = '0;
        repeat (2) @(negedge clk);
        chk("rst_mread", DW'(m_read), DW'(0));
        chk("rst_mwrite", DW'(m_write), DW'(0));
        s_read = 1'b0; s_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; in_reset = 1'b0;
        @(posedge clk); #1;

        mode = 0; do_read(49'h40, 7);
        mode = 0; do_write(49'h0, 8, -1);
        mode = 1; do_write(49'hC0, 3, 1);
        mode = 0; do_write(49'h1_0000_0000_0080, 4, -1);
        mode = 2; do_read(49'h0, 64);
        mode = 1; do_read(49'h2C0, 0);
        mode = 1; do_write(49'h1C0, 1, -1);

        // Reset while the second sub-burst of a 16-line read is on the bus.
        mode = 0; do_read(49'h0, 16);
        reset = 1'b1; in_reset = 1'b1;
        flush();
        @(negedge clk);
        chk("midrst_mread", DW'(m_read), DW'(0));
        @(posedge clk); #1;
        flush();
        reset = 1'b0; in_reset = 1'b0;
        @(negedge clk);
        chk("postrst_idle", DW'(m_read), DW'(0));
        @(posedge clk); #1;
        do_read(49'h1C0, 1);

        for (int k = 0; k < 40; k++) begin
            mode = int'($urandom % 3);
            t = {$urandom, $urandom};
            a = '0;
            a[47:6] = t[41:0];
            a[48] = ($urandom % 4 == 0);
            n = int'($urandom_range(0, 64));
            if ($urandom % 2 == 0) do_read(a, n);
            else do_write(a, n, -2);
        end

        mode = 0;
        n = 0;
        while ((exp_rdata_q.size() != 0 || resp_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        chk("end_rd_cmds", DW'(exp_rd_q.size()), DW'(0));
        chk("end_wr_beats", DW'(exp_wr_q.size()), DW'(0));
        chk("end_rdata", DW'(exp_rdata_q.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
